// File: rtl/jtdd_mixer_n_pkg.sv
// Shared widths and constants for the N-layer colour mixer and its palette.
package jtdd_mix_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_LAYERS   = 4;
  localparam int DEF_PXLW     = 8;
  localparam int DEF_TRANSW   = 4;
  localparam int DEF_PRIOSELW = 2;
  localparam int DEF_LSELW    = clog2(DEF_LAYERS);
  localparam int DEF_PALW     = DEF_LSELW + DEF_PXLW;
  localparam int DEF_PAW      = DEF_PRIOSELW + DEF_LAYERS;

  localparam int MIX_LAT = 5;

  // Value of the top CPU address bit selecting each palette byte plane,
  // and where each colour nibble sits inside a plane byte.
  localparam int PLANE_GR  = 0;
  localparam int PLANE_B   = 1;
  localparam int RED_LSB   = 0;
  localparam int GREEN_LSB = 4;
  localparam int BLUE_LSB  = 0;

endpackage

// File: rtl/jtdd_mixer_n_if.sv
// CPU palette bus between the main CPU decode and the colour mixer.
interface jtdd_mixer_n_if import jtdd_mix_pkg::*; #(
  parameter int PALW = DEF_PALW
) ();
  logic            cen_E;
  logic [PALW:0]   cpu_AB;
  logic            cpu_wrn;
  logic [7:0]      cpu_dout;
  logic            pal_cs;
  logic [7:0]      pal_dout;

  modport master (output cen_E, cpu_AB, cpu_wrn, cpu_dout, pal_cs, input pal_dout);
  modport slave  (input cen_E, cpu_AB, cpu_wrn, cpu_dout, pal_cs, output pal_dout);
endinterface

// File: rtl/jtdd_dpram.sv
// True dual-port synchronous RAM, read-before-write on both ports.
module jtdd_dpram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] q_a,
  input  logic          en_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] din_b,
  output logic [DW-1:0] q_b
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
  end

  // Read registers see the array before this edge's writes land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      if (en_a) q_a <= mem[addr_a];
      if (en_b) q_b <= mem[addr_b];
    end
  end
endmodule

// File: rtl/jtdd_mixer_n.sv
// N-layer priority mixer with CPU-writable two-plane palette and
// five-tick pixel pipeline (register, priority read, mux, palette read, out).
module jtdd_mixer_n import jtdd_mix_pkg::*; #(
  parameter  int LAYERS   = DEF_LAYERS,
  parameter  int PXLW     = DEF_PXLW,
  parameter  int TRANSW   = DEF_TRANSW,
  parameter  int PRIOSELW = DEF_PRIOSELW,
  localparam int LSELW    = clog2(LAYERS),
  localparam int PALW     = LSELW + PXLW,
  localparam int PAW      = PRIOSELW + LAYERS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pxl_cen,
  jtdd_mixer_n_if.slave          cpu,
  input  logic                   HBL,
  input  logic                   VBL,
  input  logic [LAYERS*PXLW-1:0] layer_pxl,
  input  logic [LAYERS-1:0]      gfx_en,
  input  logic [PRIOSELW-1:0]    prio_sel,
  input  logic [PAW-1:0]         prog_addr,
  input  logic [LSELW-1:0]       prom_din,
  input  logic                   prom_prio_we,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue
);
  logic cen_e_l, cpu_plane, cpu_wr, cpu_rd, rd_plane;
  logic [7:0] pal0_cpu, pal1_cpu, pal0_vid, pal1_vid;

  logic [LAYERS*PXLW-1:0] pxl_s1, pxl_s2;
  logic [LAYERS-1:0]      opq_in, opq_s1, opq_s2;
  logic [PRIOSELW-1:0]    psel_s1;
  logic [LSELW-1:0]       prio_vid, prio_prog_q, sel;
  logic [PXLW-1:0]        pix;
  logic [PALW-1:0]        pal_addr;
  logic [MIX_LAT-2:0]     lhbl_sr, lvbl_sr;
  logic                   unused_bits;

  assign cpu_plane = cpu.cpu_AB[PALW];
  // Edge on cen_E so a strobe held over several clocks still writes once.
  assign cpu_wr    = cpu.pal_cs && !cpu.cpu_wrn && cpu.cen_E && !cen_e_l;
  assign cpu_rd    = cpu.pal_cs && cpu.cpu_wrn;
  assign cpu.pal_dout = (rd_plane == 1'(PLANE_B)) ? pal1_cpu : pal0_cpu;
  assign unused_bits  = ^{prio_prog_q, pal1_vid[7:4]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cen_e_l  <= 1'b0;
      rd_plane <= 1'b0;
    end else begin
      cen_e_l <= cpu.cen_E;
      if (cpu_rd) rd_plane <= cpu_plane;
    end
  end

  always_comb begin
    opq_in = '0;
    for (int k = 0; k < LAYERS; k++)
      opq_in[k] = gfx_en[k] && (layer_pxl[k*PXLW +: TRANSW] != '0);
  end

  // A winner that is not opaque (or out of range) falls back to the backdrop.
  always_comb begin
    sel = '0;
    pix = pxl_s2[PXLW-1:0];
    for (int k = 1; k < LAYERS; k++) begin
      if (prio_vid == LSELW'(k) && opq_s2[k]) begin
        sel = LSELW'(k);
        pix = pxl_s2[k*PXLW +: PXLW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pxl_s1   <= '0;
      opq_s1   <= '0;
      psel_s1  <= '0;
      pxl_s2   <= '0;
      opq_s2   <= '0;
      pal_addr <= '0;
      lhbl_sr  <= '0;
      lvbl_sr  <= '0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
    end else if (pxl_cen) begin
      pxl_s1   <= layer_pxl;
      opq_s1   <= opq_in;
      psel_s1  <= prio_sel;
      pxl_s2   <= pxl_s1;
      opq_s2   <= opq_s1;
      pal_addr <= {sel, pix};
      lhbl_sr  <= {lhbl_sr[MIX_LAT-3:0], ~HBL};
      lvbl_sr  <= {lvbl_sr[MIX_LAT-3:0], ~VBL};
      LHBL_dly <= lhbl_sr[MIX_LAT-2];
      LVBL_dly <= lvbl_sr[MIX_LAT-2];
      if (lhbl_sr[MIX_LAT-2] && lvbl_sr[MIX_LAT-2]) begin
        red   <= pal0_vid[RED_LSB +: 4];
        green <= pal0_vid[GREEN_LSB +: 4];
        blue  <= pal1_vid[BLUE_LSB +: 4];
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

  jtdd_dpram #(.AW(PAW), .DW(LSELW)) u_prio (
    .clk, .rst,
    .en_a(1'b0), .we_a(prom_prio_we), .addr_a(prog_addr), .din_a(prom_din), .q_a(prio_prog_q),
    .en_b(pxl_cen), .we_b(1'b0), .addr_b({psel_s1, opq_s1}), .din_b('0), .q_b(prio_vid)
  );

  jtdd_dpram #(.AW(PALW), .DW(8)) u_pal_gr (
    .clk, .rst,
    .en_a(cpu_rd), .we_a(cpu_wr && cpu_plane == 1'(PLANE_GR)),
    .addr_a(cpu.cpu_AB[PALW-1:0]), .din_a(cpu.cpu_dout), .q_a(pal0_cpu),
    .en_b(pxl_cen), .we_b(1'b0), .addr_b(pal_addr), .din_b('0), .q_b(pal0_vid)
  );

  // Blue plane keeps only the low nibble; the upper nibble always reads 0.
  jtdd_dpram #(.AW(PALW), .DW(8)) u_pal_b (
    .clk, .rst,
    .en_a(cpu_rd), .we_a(cpu_wr && cpu_plane == 1'(PLANE_B)),
    .addr_a(cpu.cpu_AB[PALW-1:0]), .din_a({4'h0, cpu.cpu_dout[BLUE_LSB +: 4]}), .q_a(pal1_cpu),
    .en_b(pxl_cen), .we_b(1'b0), .addr_b(pal_addr), .din_b('0), .q_b(pal1_vid)
  );
endmodule

// File: tb/tb_jtdd_mixer_n.sv
// Self-checking bench for jtdd_mixer_n with a behavioural palette/priority model.
module tb_jtdd_mixer_n;
  logic        clk = 1'b0, rst = 1'b1, pxl_cen = 1'b0, HBL = 1'b0, VBL = 1'b0;
  logic        prom_prio_we = 1'b0;
  logic [31:0] layer_pxl = '0;
  logic [3:0]  gfx_en = 4'hF;
  logic [1:0]  prio_sel = '0, prom_din = '0;
  logic [5:0]  prog_addr = '0;
  logic [3:0]  red, green, blue;
  logic        LHBL_dly, LVBL_dly;

  int n_checks = 0, n_bad = 0;

  typedef struct packed {
    logic [3:0] r, g, b;
    logic       lh, lv;
  } exp_t;

  logic [7:0] pal0_m [1024];
  logic [7:0] pal1_m [1024];
  logic [1:0] prio_m [64];
  exp_t       expq [$];
  exp_t       cur_exp;

  jtdd_mixer_n_if #(.PALW(10)) bus ();

  jtdd_mixer_n dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cpu(bus.slave),
    .HBL(HBL), .VBL(VBL), .layer_pxl(layer_pxl), .gfx_en(gfx_en), .prio_sel(prio_sel),
    .prog_addr(prog_addr), .prom_din(prom_din), .prom_prio_we(prom_prio_we),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Colour the spec's rules give for the current inputs and model RAM contents.
  function automatic exp_t model_pixel();
    exp_t e;
    logic [3:0] opq;
    logic [7:0] px;
    int sel, addr;
    for (int k = 0; k < 4; k++) begin
      px = layer_pxl[k*8 +: 8];
      opq[k] = gfx_en[k] && (px[3:0] != 4'h0);
    end
    sel = int'(prio_m[{prio_sel, opq}]);
    if (!opq[sel]) sel = 0;
    px = layer_pxl[sel*8 +: 8];
    addr = sel * 256 + int'(px);
    e.lh = !HBL;
    e.lv = !VBL;
    if (HBL || VBL) begin
      e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
    end else begin
      e.r = pal0_m[addr][3:0];
      e.g = pal0_m[addr][7:4];
      e.b = pal1_m[addr][3:0];
    end
    return e;
  endfunction

  task automatic tick(input bit cen);
    exp_t e;
    e = model_pixel();
    pxl_cen = cen;
    @(posedge clk);
    if (cen) begin
      expq.push_back(e);
      if (expq.size() > 5) void'(expq.pop_front());
      cur_exp = expq[0];
    end
    #1;
    pxl_cen = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    repeat (4) expq.push_back('0);
    cur_exp = '0;
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    bus.pal_cs = 1'b1; bus.cpu_wrn = 1'b0; bus.cpu_AB = a; bus.cpu_dout = d; bus.cen_E = 1'b1;
    @(posedge clk); #1;
    bus.pal_cs = 1'b0; bus.cpu_wrn = 1'b1; bus.cen_E = 1'b0;
    @(posedge clk); #1;
    if (a[10]) pal1_m[a[9:0]] = {4'h0, d[3:0]};
    else       pal0_m[a[9:0]] = d;
  endtask

  task automatic cpu_read(input logic [10:0] a, output logic [7:0] d);
    bus.pal_cs = 1'b1; bus.cpu_wrn = 1'b1; bus.cpu_AB = a;
    @(posedge clk); #1;
    d = bus.pal_dout;
    bus.pal_cs = 1'b0;
  endtask

  task automatic prio_write(input logic [5:0] a, input logic [1:0] d);
    prog_addr = a; prom_din = d; prom_prio_we = 1'b1;
    @(posedge clk); #1;
    prom_prio_we = 1'b0;
    prio_m[a] = d;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({red, green, blue, LHBL_dly, LVBL_dly} !== 14'h0 || bus.pal_dout !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_state got rgb=%h%h%h hb=%b vb=%b dout=%h want all 0",
               red, green, blue, LHBL_dly, LVBL_dly, bus.pal_dout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({red, green, blue, LHBL_dly, LVBL_dly} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_release got rgb=%h%h%h hb=%b want 0", red, green, blue, LHBL_dly);
    end
  endtask

  task automatic test_single_layer();
    for (int a = 0; a < 16; a++) prio_write(6'(a), 2'd1);
    cpu_write(11'h112, 8'hA5);
    cpu_write(11'h512, 8'h03);
    layer_pxl = 32'h0000_1200; gfx_en = 4'hF; prio_sel = 2'd0; HBL = 1'b0; VBL = 1'b0;
    repeat (4) tick(1'b1);
    n_checks++;
    if ({red, green, blue, LHBL_dly, LVBL_dly} !== 14'h0) begin
      n_bad++;
      $display("FAIL single_tick4 got rgb=%h%h%h hb=%b want 000 hb=0", red, green, blue, LHBL_dly);
    end
    tick(1'b1);
    n_checks++;
    if ({red, green, blue, LHBL_dly, LVBL_dly} !== {4'h5, 4'hA, 4'h3, 2'b11}) begin
      n_bad++;
      $display("FAIL single_tick5 got rgb=%h%h%h hb=%b vb=%b want 5A3 11",
               red, green, blue, LHBL_dly, LVBL_dly);
    end
  endtask

  task automatic test_priority();
    prio_write(6'h16, 2'd2);
    cpu_write(11'h245, 8'h3C);
    cpu_write(11'h645, 8'h09);
    layer_pxl = 32'h0045_1200; prio_sel = 2'd0;
    repeat (5) tick(1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h5A3) begin
      n_bad++;
      $display("FAIL prio_bank0 got=%h%h%h want=5A3", red, green, blue);
    end
    prio_sel = 2'd1;
    repeat (4) tick(1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h5A3) begin
      n_bad++;
      $display("FAIL prio_latency got=%h%h%h want=5A3", red, green, blue);
    end
    tick(1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'hC39) begin
      n_bad++;
      $display("FAIL prio_bank1 got=%h%h%h want=C39", red, green, blue);
    end
  endtask

  task automatic test_reset_midframe();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({red, green, blue, LHBL_dly, LVBL_dly} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_async got rgb=%h%h%h hb=%b vb=%b want 0", red, green, blue, LHBL_dly, LVBL_dly);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) tick(1'b1);
    n_checks++;
    if ({red, green, blue, LHBL_dly} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_refill got rgb=%h%h%h hb=%b want 0", red, green, blue, LHBL_dly);
    end
    tick(1'b1);
    n_checks++;
    if ({red, green, blue, LHBL_dly} !== {12'hC39, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_resume got rgb=%h%h%h hb=%b want C39 1", red, green, blue, LHBL_dly);
    end
  endtask

  task automatic test_transparency();
    prio_write(6'h12, 2'd2);
    cpu_write(11'h050, 8'hE1);
    cpu_write(11'h450, 8'h0F);
    layer_pxl = 32'h0030_1250; prio_sel = 2'd1; gfx_en = 4'hF;
    repeat (5) tick(1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h1EF) begin
      n_bad++;
      $display("FAIL transp_fallback got=%h%h%h want=1EF", red, green, blue);
    end
    prio_sel = 2'd0;
    repeat (5) tick(1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h5A3) begin
      n_bad++;
      $display("FAIL transp_layer1 got=%h%h%h want=5A3", red, green, blue);
    end
    gfx_en = 4'b1101;
    repeat (5) tick(1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h1EF) begin
      n_bad++;
      $display("FAIL mask_layer1 got=%h%h%h want=1EF", red, green, blue);
    end
    gfx_en = 4'hF;
  endtask

  task automatic test_collision();
    logic [7:0] d;
    layer_pxl = 32'h0000_1200; prio_sel = 2'd0; gfx_en = 4'hF;
    repeat (6) tick(1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h5A3) begin
      n_bad++;
      $display("FAIL coll_pre got=%h%h%h want=5A3", red, green, blue);
    end
    bus.pal_cs = 1'b1; bus.cpu_wrn = 1'b0; bus.cpu_AB = 11'h112; bus.cpu_dout = 8'h77; bus.cen_E = 1'b1;
    tick(1'b1);
    bus.pal_cs = 1'b0; bus.cpu_wrn = 1'b1; bus.cen_E = 1'b0;
    pal0_m[10'h112] = 8'h77;
    tick(1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h5A3) begin
      n_bad++;
      $display("FAIL coll_old got=%h%h%h want=5A3", red, green, blue);
    end
    tick(1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h773) begin
      n_bad++;
      $display("FAIL coll_new got=%h%h%h want=773", red, green, blue);
    end
    cpu_read(11'h112, d);
    n_checks++;
    if (d !== 8'h77) begin n_bad++; $display("FAIL cpu_read_gr got=%h want=77", d); end
    cpu_read(11'h512, d);
    n_checks++;
    if (d !== 8'h03) begin n_bad++; $display("FAIL cpu_read_b got=%h want=03", d); end
    cpu_write(11'h512, 8'hF6);
    cpu_read(11'h512, d);
    n_checks++;
    if (d !== 8'h06) begin n_bad++; $display("FAIL cpu_b_nibble got=%h want=06", d); end
    cpu_write(11'h512, 8'h03);
  endtask

  function automatic logic want_lh(input int n);
    return !(n >= 5 && n <= 7);
  endfunction

  task automatic test_blanking();
    int n_low, first_low, gaps;
    n_low = 0; first_low = 0;
    HBL = 1'b0;
    repeat (6) tick(1'b1);
    for (int n = 1; n <= 10; n++) begin
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        HBL = 1'($urandom);
        pxl_cen = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (LHBL_dly !== want_lh(n - 1) || {red, green, blue} !== (want_lh(n - 1) ? 12'h773 : 12'h000)) begin
          n_bad++;
          $display("FAIL blank_gap n=%0d got hb=%b rgb=%h%h%h want hb=%b", n, LHBL_dly, red, green, blue, want_lh(n - 1));
        end
      end
      HBL = (n <= 3);
      tick(1'b1);
      n_checks++;
      if (LHBL_dly !== want_lh(n) || {red, green, blue} !== (want_lh(n) ? 12'h773 : 12'h000)) begin
        n_bad++;
        $display("FAIL blank_tick n=%0d got hb=%b rgb=%h%h%h want hb=%b", n, LHBL_dly, red, green, blue, want_lh(n));
      end
      if (LHBL_dly === 1'b0) begin
        n_low++;
        if (first_low == 0) first_low = n;
      end
    end
    HBL = 1'b0;
    n_checks++;
    if (n_low != 3 || first_low != 5) begin
      n_bad++;
      $display("FAIL blank_window got len=%0d start=%0d want len=3 start=5", n_low, first_low);
    end
  endtask

  task automatic test_random();
    logic [7:0] px;
    do_reset();
    for (int a = 0; a < 1024; a++) begin
      cpu_write(11'(a), 8'($urandom));
      cpu_write(11'(a + 1024), 8'($urandom));
    end
    for (int a = 0; a < 64; a++) prio_write(6'(a), 2'($urandom));
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        px = 8'($urandom);
        if ($urandom_range(0, 2) == 0) px[3:0] = 4'h0;
        layer_pxl[k*8 +: 8] = px;
      end
      gfx_en   = 4'($urandom);
      prio_sel = 2'($urandom);
      HBL      = ($urandom_range(0, 7) == 0);
      VBL      = ($urandom_range(0, 9) == 0);
      tick($urandom_range(0, 3) != 0);
      n_checks++;
      if ({red, green, blue, LHBL_dly, LVBL_dly} !== cur_exp) begin
        n_bad++;
        $display("FAIL random c=%0d got rgb=%h%h%h hb=%b vb=%b want rgb=%h%h%h hb=%b vb=%b", c,
                 red, green, blue, LHBL_dly, LVBL_dly, cur_exp.r, cur_exp.g, cur_exp.b, cur_exp.lh, cur_exp.lv);
      end
    end
    HBL = 1'b0; VBL = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin pal0_m[a] = '0; pal1_m[a] = '0; end
    for (int a = 0; a < 64; a++) prio_m[a] = '0;
    cur_exp = '0;
    bus.cen_E = 1'b0; bus.cpu_AB = '0; bus.cpu_wrn = 1'b1; bus.cpu_dout = '0; bus.pal_cs = 1'b0;
    test_reset();
    test_single_layer();
    test_priority();
    test_reset_midframe();
    test_transparency();
    test_collision();
    test_blanking();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule

// File: doc/jtdd_mixer_n.md
Name: jtdd_mixer_n

Overview:
Parametrised N-layer colour mixer and palette stage; successor to the fixed three-layer char/scroll/object mixer in the video top level.
- Takes LAYERS layer pixel indices, resolves transparency and priority through a programmable priority table, then looks up a CPU-writable palette.
- Emits 4-bit RGB plus delayed blanking to the video output.
- Adds per-layer enable masking and a selectable priority bank, which the three-layer mixer lacks.

Parameters:
LAYERS, 4, number of input layers (2..8); layer 0 is the backdrop layer.
PXLW, 8, pixel index width per layer.
TRANSW, 4, low bits of a layer pixel that mark it transparent when all zero (TRANSW<=PXLW).
PRIOSELW, 2, width of the priority bank select.
Derived localparams: LSELW=clog2(LAYERS); PALW=LSELW+PXLW; PAW=PRIOSELW+LAYERS.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
pxl_cen  in  1  pixel clock enable
cen_E  in  1  CPU bus strobe enable
cpu_AB  in  PALW+1  palette byte address; bit PALW selects byte plane
cpu_wrn  in  1  CPU write, active-low
cpu_dout  in  8  CPU write data
pal_cs  in  1  palette chip select
pal_dout  out  8  palette read data
HBL  in  1  horizontal blank, active-high
VBL  in  1  vertical blank, active-high
layer_pxl  in  LAYERS*PXLW  packed layer pixels; layer k at [k*PXLW+:PXLW]
gfx_en  in  LAYERS  per-layer enable; 0 forces that layer transparent
prio_sel  in  PRIOSELW  priority table bank
prog_addr  in  PAW  priority table program address
prom_din  in  LSELW  priority table program data (winning layer)
prom_prio_we  in  1  priority table write strobe
LHBL_dly  out  1  delayed horizontal blank, active-low
LVBL_dly  out  1  delayed vertical blank, active-low
red, green, blue  out  4 each  colour output

Behaviour:
- Reset (async, rst=1): red/green/blue=0, LHBL_dly=LVBL_dly=0, pal_dout=0, all pipeline registers cleared. Palette and priority RAM contents are not cleared.
- The pipeline advances only on clk edges with pxl_cen=1. Latency is exactly 5 pxl_cen ticks from layer_pxl/HBL/VBL to RGB/LHBL_dly/LVBL_dly.
- S1: register pixels. opaque[k] = gfx_en[k] && (pxl_k[TRANSW-1:0] != 0).
- S2: synchronous priority RAM read at {prio_sel, opaque}, giving sel[LSELW-1:0].
  - If the selected layer's opaque bit is 0, force sel=0 (backdrop). Layer 0 is shown even when transparent.
- S3: palette address = {sel, pxl_sel}.
- S4: synchronous palette read.
- S5: output register. If either delayed blank is active, RGB=0; otherwise RGB = palette entry.
- Blank pipeline: HBL/VBL are inverted and delayed 5 ticks in lockstep with the data.
- Palette storage: two byte planes, each 2^PALW deep.
  - Plane 0 (cpu_AB[PALW]=0) holds {green[3:0], red[3:0]}.
  - Plane 1 holds {4'b0, blue[3:0]}; the upper nibble of plane 1 writes are ignored and read as 0.
- CPU write: when pal_cs && !cpu_wrn && cen_E, exactly one write per cen_E pulse.
- CPU read: pal_dout is registered one clk after pal_cs && cpu_wrn and held otherwise.
- CPU/video collision on the same entry in the same clk: the video port returns old data (read-before-write). The CPU is never stalled.
- prom_prio_we writes prom_din at prog_addr independently of pxl_cen. Writing during active video is allowed and takes effect on the next S2 read.
- pxl_cen gaps: all pipeline state holds. The CPU port keeps operating.

Decomposition:
- Package jtdd_mix_pkg holds:
  - the clog2 helper and the derived width localparams;
  - MIX_LAT=5;
  - the plane-select bit-position constants.
- One sub-module, jtdd_dpram: parametrised true dual-port synchronous RAM (AW, DW), read-before-write. It is instantiated twice for the palette planes and once for the priority table, with the program port on A and the video read on B.

Test Plan:
- Reset: assert rst mid-frame -> RGB=0 and LHBL_dly=LVBL_dly=0 immediately, without waiting for a clk edge. After release, outputs stay 0 until 5 pxl_cen ticks of unblanked input.
- Single layer: program every entry of bank 0 to 1; plane0[0x112]=0xA5, plane1[0x112]=0x03; layer1=0x12, others 0, HBL=VBL=0 -> after exactly 5 pxl_cen: red=5, green=A, blue=3.
- Priority: bank 1 entry opaque=4'b0110 -> 2, bank 0 same entry -> 1; toggle prio_sel 0->1 -> output switches from layer 1's colour to layer 2's colour.
- Transparency/mask: layer2=0x30 (low nibble 0) selected -> falls back to layer 0, address {0, pxl0}. With gfx_en[1]=0 and layer1=0x12 -> layer 1 is treated as transparent.
- Collision: CPU writes plane0[0x112]=0x77 in the same clk as the video read of 0x112 -> that pixel shows the old 0xA5 colour, the next pixel shows 0x77. A CPU read returns 0x77.
- Blanking and gaps: HBL=1 for 3 ticks with random pxl_cen gaps -> LHBL_dly low for exactly 3 ticks starting 5 ticks later, with RGB=0 during that window.
